// File: rtl/ex_divider_pkg.sv
// Shared types for the EX-stage integer divider.
//   DType    : 32-bit operand/result word
//   DivOp    : divide/remainder operation code
//   DivState : divider FSM state
//   DIV_ITER : restoring iterations per divide
package ex_divider_pkg;

  typedef logic [31:0] DType;

  typedef enum logic [1:0] {
    DIV_W  = 2'd0,
    DIV_WU = 2'd1,
    MOD_W  = 2'd2,
    MOD_WU = 2'd3
  } DivOp;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } DivState;

  localparam int unsigned DIV_ITER = 32;

  function automatic logic is_signed_op(DivOp op);
    return (op == DIV_W) || (op == MOD_W);
  endfunction

  // MOD_W and MOD_WU both have bit 1 set.
  function automatic logic is_mod_op(DivOp op);
    return op[1];
  endfunction

endpackage

// File: rtl/ex_divider_div_step.sv
// One restoring-division step, purely combinational.
//   rem, quo        : current partial remainder and quotient/dividend shift register
//   dvs             : divisor magnitude
//   rem_next/quo_next : values after shifting left one bit and trial-subtracting
module ex_divider_div_step
  import ex_divider_pkg::*;
(
  input  DType rem,
  input  DType quo,
  input  DType dvs,
  output DType rem_next,
  output DType quo_next
);

  logic [32:0] rem_sh;
  logic [32:0] diff;

  // rem < dvs always holds, so rem_sh < 2*dvs and a 33-bit difference is enough:
  // bit 32 set means the trial subtraction went negative.
  assign rem_sh = {rem, quo[31]};
  assign diff   = rem_sh - {1'b0, dvs};

  always_comb begin
    rem_next = rem_sh[31:0];
    quo_next = {quo[30:0], 1'b0};
    if (!diff[32]) begin
      rem_next = diff[31:0];
      quo_next = {quo[30:0], 1'b1};
    end
  end

endmodule

// File: rtl/ex_divider.sv
// Iterative 32-bit integer divider for the EX stage (DIV.W, DIV.WU, MOD.W, MOD.WU).
//   clk, rst             : core clock, synchronous active-high reset
//   div_valid, div_op    : divide request and operation, held while div_stall=1
//   rj_ex_true/rk_ex_true: forwarded dividend / divisor, sampled only when accepted
//   flush                : kill the instruction in EX
//   div_stall            : freeze IF/ID/EX while the divide is in progress
//   div_done, div_result : one-cycle completion pulse and registered, held result
module ex_divider
  import ex_divider_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              div_valid,
  input  logic [1:0]        div_op,
  input  logic [DATA_W-1:0] rj_ex_true,
  input  logic [DATA_W-1:0] rk_ex_true,
  input  logic              flush,
  output logic              div_stall,
  output logic              div_done,
  output logic [DATA_W-1:0] div_result
);

  localparam logic [4:0] LastCnt = 5'(DIV_ITER - 1);

  DivState    state_q;
  logic [4:0] cnt_q;
  DivOp       op_q;
  DType       rem_q, quo_q, dvs_q;
  logic       q_neg_q, r_neg_q;

  DivOp op_in;
  logic a_neg, b_neg;
  DType abs_a, abs_b;
  DType step_rem, step_quo;
  DType fin_q, fin_r, fin;

  assign op_in = DivOp'(div_op);
  assign a_neg = is_signed_op(op_in) & rj_ex_true[31];
  assign b_neg = is_signed_op(op_in) & rk_ex_true[31];
  assign abs_a = a_neg ? -rj_ex_true : rj_ex_true;
  assign abs_b = b_neg ? -rk_ex_true : rk_ex_true;

  ex_divider_div_step u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .dvs      (dvs_q),
    .rem_next (step_rem),
    .quo_next (step_quo)
  );

  // Taken from the final step's outputs so the result registers on the edge into DONE.
  // 0x8000_0000 / -1 needs no special case: the magnitude quotient 0x8000_0000
  // negates to itself.
  assign fin_q = q_neg_q ? -step_quo : step_quo;
  assign fin_r = r_neg_q ? -step_rem : step_rem;
  assign fin   = is_mod_op(op_q) ? fin_r : fin_q;

  assign div_stall = !flush && (((state_q == IDLE) && div_valid) || (state_q == CALC));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_q       <= DIV_W;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      div_done   <= 1'b0;
      div_result <= '0;
    end else begin
      div_done <= 1'b0;
      if (flush) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (div_valid) begin
              op_q    <= op_in;
              rem_q   <= '0;
              quo_q   <= abs_a;
              dvs_q   <= abs_b;
              q_neg_q <= a_neg ^ b_neg;
              r_neg_q <= a_neg;
              cnt_q   <= '0;
              if (rk_ex_true == '0) begin
                // Divide by zero: all-ones quotient, raw dividend as remainder.
                state_q    <= DONE;
                div_done   <= 1'b1;
                div_result <= is_mod_op(op_in) ? rj_ex_true : '1;
              end else begin
                state_q <= CALC;
              end
            end
          end
          CALC: begin
            rem_q <= step_rem;
            quo_q <= step_quo;
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == LastCnt) begin
              state_q    <= DONE;
              cnt_q      <= '0;
              div_done   <= 1'b1;
              div_result <= fin;
            end
          end
          DONE: state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ex_divider.sv
module tb_ex_divider;
  import ex_divider_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        div_valid;
  logic [1:0]  div_op;
  logic [31:0] rj_ex_true;
  logic [31:0] rk_ex_true;
  logic        flush;
  logic        div_stall;
  logic        div_done;
  logic [31:0] div_result;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  ex_divider #(.DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .div_valid  (div_valid),
    .div_op     (div_op),
    .rj_ex_true (rj_ex_true),
    .rk_ex_true (rk_ex_true),
    .flush      (flush),
    .div_stall  (div_stall),
    .div_done   (div_done),
    .div_result (div_result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one divide and follow it to completion. Operands are scrambled after the
  // accept cycle to show they are not re-sampled. Leaves div_valid high on return.
  task automatic run_div(input string tag, input DivOp op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat,
                         output int done_cyc);
    int seen;
    int stalls;
    logic stall_at_done;
    seen          = -1;
    stalls        = 0;
    stall_at_done = 1'b1;
    done_cyc      = -1;
    @(negedge clk);
    div_valid  = 1'b1;
    div_op     = op;
    rj_ex_true = a;
    rk_ex_true = b;
    #1;
    for (int c = 0; c < 40 && seen < 0; c++) begin
      if (div_done) begin
        seen          = c;
        done_cyc      = cyc;
        stall_at_done = div_stall;
      end else if (div_stall) begin
        stalls++;
      end
      if (seen < 0) begin
        @(negedge clk);
        if (c == 0) begin
          rj_ex_true = ~a;
          rk_ex_true = b ^ 32'h5a5a_0003;
        end
        #1;
      end
    end
    chk({tag, "_latency"}, seen, lat);
    chk({tag, "_stall_cycles"}, stalls, lat);
    chk({tag, "_stall_at_done"}, {31'd0, stall_at_done}, 32'd0);
    chk({tag, "_result"}, div_result, exp);
  endtask

  task automatic idle_chk(input string tag);
    @(negedge clk);
    div_valid = 1'b0;
    #1;
    chk({tag, "_done_single"}, {31'd0, div_done}, 32'd0);
    @(negedge clk);
  endtask

  int d0, d1;
  int any_done;

  initial begin
    rst        = 1'b1;
    div_valid  = 1'b0;
    div_op     = 2'd0;
    rj_ex_true = '0;
    rk_ex_true = '0;
    flush      = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("reset_stall", {31'd0, div_stall}, 32'd0);
    chk("reset_done", {31'd0, div_done}, 32'd0);
    chk("reset_result", div_result, 32'd0);

    run_div("divw_m7_2", DIV_W, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, d0);
    idle_chk("divw_m7_2");
    run_div("modw_m7_2", MOD_W, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, d0);
    idle_chk("modw_m7_2");
    run_div("modwu_big_2", MOD_WU, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 33, d0);
    idle_chk("modwu_big_2");
    run_div("modw_7_m2", MOD_W, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 33, d0);
    idle_chk("modw_7_m2");
    run_div("divw_7_m2", DIV_W, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, d0);
    idle_chk("divw_7_m2");
    run_div("divwu_by0", DIV_WU, 32'd100, 32'd0, 32'hFFFF_FFFF, 1, d0);
    idle_chk("divwu_by0");
    run_div("modw_by0", MOD_W, 32'hFFFF_FF9C, 32'd0, 32'hFFFF_FF9C, 1, d0);
    idle_chk("modw_by0");
    run_div("divw_ovf", DIV_W, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, d0);
    idle_chk("divw_ovf");

    // Flush in the 10th CALC cycle.
    @(negedge clk);
    div_valid  = 1'b1;
    div_op     = DIV_W;
    rj_ex_true = 32'd123456;
    rk_ex_true = 32'd7;
    #1;
    chk("flush_stall_accept", {31'd0, div_stall}, 32'd1);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    #1;
    chk("flush_stall_low", {31'd0, div_stall}, 32'd0);
    @(negedge clk);
    flush     = 1'b0;
    div_valid = 1'b0;
    any_done  = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (div_done) any_done = 1;
      @(negedge clk);
    end
    chk("flush_no_done", any_done, 0);
    chk("flush_result_held", div_result, 32'h8000_0000);
    chk("flush_stall_idle", {31'd0, div_stall}, 32'd0);
    run_div("divwu_1000_7", DIV_WU, 32'd1000, 32'd7, 32'd142, 33, d0);
    idle_chk("divwu_1000_7");

    // Reset in the middle of CALC.
    @(negedge clk);
    div_valid  = 1'b1;
    div_op     = DIV_WU;
    rj_ex_true = 32'd1000;
    rk_ex_true = 32'd3;
    repeat (5) @(negedge clk);
    rst       = 1'b1;
    div_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_mid_stall", {31'd0, div_stall}, 32'd0);
    chk("rst_mid_done", {31'd0, div_done}, 32'd0);
    chk("rst_mid_result", div_result, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_mid_stall_after", {31'd0, div_stall}, 32'd0);

    run_div("modw_ovf", MOD_W, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33, d0);
    idle_chk("modw_ovf");

    // Back-to-back: second request presented right after the first done cycle.
    run_div("b2b_divwu", DIV_WU, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 33, d0);
    run_div("b2b_divw", DIV_W, 32'd50, 32'hFFFF_FFFB, 32'hFFFF_FFF6, 33, d1);
    chk("b2b_done_spacing", d1 - d0, 34);
    idle_chk("b2b_divw");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
